// File: rtl/instruction_fetcher_pkg.sv
// Shared fetch-stage definitions.
//   fetch_state_t : request sequencer states of the fetcher
//   fetch_item_t  : one fetched item as seen by decode {misaligned, instruction, address}
//   INSTR_BYTES   : size of one instruction word in bytes (pc stride)
//   isMisaligned  : true when the low pc bits do not select a word boundary
package instruction_fetcher_pkg;

   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQUEST,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic        misaligned;
      logic [31:0] instruction;
      logic [31:0] address;
   } fetch_item_t;

   function automatic logic isMisaligned(input logic [1:0] lowBits);
      return (lowBits & 2'(INSTR_BYTES - 1)) != 2'b00;
   endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Instruction bus between the fetcher (master) and the shared memory port (slave).
//   req   : master -> slave  read request, held until ack
//   addr  : master -> slave  read address, stable while req is held
//   ack   : slave  -> master request completes this cycle, rdata valid
//   rdata : slave  -> master read data
interface instruction_fetcher_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetcher_slot.sv
// One-entry valid/ready output register between fetch and the decode skid buffer.
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   flush            : empties the slot at the next edge, beats any load
//   load             : write a new item this cycle
//   loadMisaligned   : the item being loaded is an alignment fault marker
//   loadInstruction  : instruction word of the new item
//   loadAddress      : pc of the new item
//   out_ready        : downstream takes the presented item this cycle
//   out_valid, out_instruction, out_address, out_misaligned : presented item
module instruction_fetcher_slot #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  load,
   input  logic                  loadMisaligned,
   input  logic [DATA_WIDTH-1:0] loadInstruction,
   input  logic [ADDR_WIDTH-1:0] loadAddress,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_instruction,
   output logic [ADDR_WIDTH-1:0] out_address,
   output logic                  out_misaligned
);

   // Flush has priority so a redirect never lets a stale item through; a load
   // overwrites (the fetcher only loads when the slot is empty or draining);
   // otherwise the item stays put until the consumer takes it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_address     <= '0;
         out_misaligned  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid       <= 1'b1;
         out_instruction <= loadInstruction;
         out_address     <= loadAddress;
         out_misaligned  <= loadMisaligned;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetcher.sv
// Front stage of the RV32E core: reads the word at pc over the instruction bus
// and hands {instruction, address} to decode through a one-entry output slot.
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   pc              : fetch address, owned by the pc register
//   flush           : redirect, drops all fetch state this cycle
//   increment       : pulse telling the pc owner to advance by one instruction
//   bus             : instruction bus master (req/addr/ack/rdata)
//   out_valid/out_ready : handshake towards decode
//   out_instruction, out_address, out_misaligned : presented item
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ALIGN_CHECK = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  pc,
   input  logic                   flush,
   output logic                   increment,
   instruction_fetcher_if.master  bus,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_instruction,
   output logic [ADDR_WIDTH-1:0]  out_address,
   output logic                   out_misaligned
);

   fetch_state_t          state;
   fetch_state_t          nextState;
   logic [ADDR_WIDTH-1:0] heldAddr;
   logic [ADDR_WIDTH-1:0] addrNow;
   logic                  faultHold;
   logic                  slotFree;
   logic                  pcMisaligned;
   logic                  requestNow;
   logic                  loadWord;
   logic                  loadFault;

   assign slotFree     = !out_valid || out_ready;
   assign pcMisaligned = (ALIGN_CHECK != 0) && isMisaligned(pc[1:0]);

   // State register plus the two pieces of fetch context: the address of a
   // request that outlives its first cycle (the pc owner may redirect pc while
   // the bus still expects the old address), and the fault hold that stops
   // fetching after an alignment fault until the next redirect.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         heldAddr  <= '0;
         faultHold <= 1'b0;
      end else begin
         state <= nextState;
         if (state == IDLE && requestNow && !bus.ack) begin
            heldAddr <= pc;
         end
         if (flush) begin
            faultHold <= 1'b0;
         end else if (loadFault) begin
            faultHold <= 1'b1;
         end
      end
   end

   // Request sequencing. IDLE issues a request straight from pc and, with a
   // zero-wait ack, completes it in the same cycle. Once a request has been
   // issued it is held until ack no matter what; a flush only decides whether
   // the returning data is kept (REQUEST) or thrown away (DISCARD).
   always_comb begin
      nextState  = state;
      requestNow = 1'b0;
      addrNow    = heldAddr;
      loadWord   = 1'b0;
      loadFault  = 1'b0;
      case (state)
         IDLE: begin
            addrNow = pc;
            if (slotFree && !flush && !faultHold) begin
               if (pcMisaligned) begin
                  loadFault = 1'b1;
               end else begin
                  requestNow = 1'b1;
                  if (bus.ack) begin
                     loadWord = 1'b1;
                  end else begin
                     nextState = REQUEST;
                  end
               end
            end
         end
         REQUEST: begin
            requestNow = 1'b1;
            if (bus.ack) begin
               loadWord  = !flush;
               nextState = IDLE;
            end else if (flush) begin
               nextState = DISCARD;
            end
         end
         DISCARD: begin
            requestNow = 1'b1;
            if (bus.ack) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Bus and pc-owner outputs are forced low while reset is held so an
   // abandoned request is visibly withdrawn from the bus.
   assign bus.req   = requestNow && !reset;
   assign bus.addr  = reset ? '0 : addrNow;
   assign increment = loadWord && !reset;

   instruction_fetcher_slot #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) outputSlot (
      .clock           (clock),
      .reset           (reset),
      .flush           (flush),
      .load            (loadWord || loadFault),
      .loadMisaligned  (loadFault),
      .loadInstruction (loadFault ? '0 : bus.rdata),
      .loadAddress     (addrNow),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .out_instruction (out_instruction),
      .out_address     (out_address),
      .out_misaligned  (out_misaligned)
   );

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;
   import instruction_fetcher_pkg::*;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        outReady;
   logic [31:0] pcReg;
   logic [31:0] flushTarget;
   logic        increment;
   logic        outValid;
   logic [31:0] outInstruction;
   logic [31:0] outAddress;
   logic        outMisaligned;

   int          checks;
   int          errors;
   int          handshakes;
   int          waitCount;
   int          waitTarget;
   int          fixedWait;
   logic        randomWaits;
   logic        incSeen;

   fetch_item_t expectQ[$];

   logic        prevFlush;
   logic        prevHold;
   logic        prevInc;
   logic        prevReqWait;
   logic [64:0] prevItem;
   logic [31:0] prevPc;
   logic [31:0] prevAddr;

   instruction_fetcher_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) busIf ();

   instruction_fetcher #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .ALIGN_CHECK(1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pc              (pcReg),
      .flush           (flush),
      .increment       (increment),
      .bus             (busIf),
      .out_valid       (outValid),
      .out_ready       (outReady),
      .out_instruction (outInstruction),
      .out_address     (outAddress),
      .out_misaligned  (outMisaligned)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory contents: every word is a fixed scramble of its own address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
   endfunction

   // Wait length chosen for the next bus request.
   function automatic int pickWait();
      if (randomWaits) begin
         return ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      end
      return fixedWait;
   endfunction

   // Memory slave: acks once the request has been held for waitTarget cycles.
   always @(posedge clock) begin
      if (busIf.req && !busIf.ack) begin
         waitCount <= waitCount + 1;
      end else begin
         waitCount  <= 0;
         waitTarget <= pickWait();
      end
   end
   assign busIf.ack   = busIf.req && (waitCount >= waitTarget);
   assign busIf.rdata = memWord(busIf.addr);

   // pc owner: redirects on flush, otherwise advances one word per increment.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         pcReg <= 32'h0;
      end else if (flush) begin
         pcReg <= flushTarget;
      end else if (incSeen) begin
         pcReg <= pcReg + 32'd4;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: after a redirect the decode side must see the words at
   // target, target+4, ... in order, or a single fault item if target is not
   // word aligned.
   task automatic redirectModel(input logic [31:0] target);
      fetch_item_t it;
      expectQ.delete();
      if (target[1:0] != 2'b00) begin
         it.misaligned  = 1'b1;
         it.instruction = 32'h0;
         it.address     = target;
         expectQ.push_back(it);
      end else begin
         for (int k = 0; k < 48; k++) begin
            it.misaligned  = 1'b0;
            it.address     = target + 32'(4 * k);
            it.instruction = memWord(it.address);
            expectQ.push_back(it);
         end
      end
   endtask

   task automatic applyStimulus(input logic f, input logic [31:0] target, input logic rdy);
      @(posedge clock);
      #1;
      flush       = f;
      flushTarget = target;
      outReady    = rdy;
      if (f) begin
         redirectModel(target);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " bus_req"}, 128'(busIf.req), 128'(0));
      checkOutput({tag, " bus_addr"}, 128'(busIf.addr), 128'(0));
      checkOutput({tag, " increment"}, 128'(increment), 128'(0));
      checkOutput({tag, " out_valid"}, 128'(outValid), 128'(0));
      checkOutput({tag, " out_instruction"}, 128'(outInstruction), 128'(0));
      checkOutput({tag, " out_address"}, 128'(outAddress), 128'(0));
      checkOutput({tag, " out_misaligned"}, 128'(outMisaligned), 128'(0));
   endtask

   // Monitor: pops the scoreboard on every accepted item and checks the
   // cycle-to-cycle protocol rules of the output slot and the bus.
   always @(negedge clock) begin
      fetch_item_t expItem;
      if (reset) begin
         incSeen     = 1'b0;
         prevFlush   = 1'b0;
         prevHold    = 1'b0;
         prevInc     = 1'b0;
         prevReqWait = 1'b0;
      end else begin
         incSeen = increment;
         if (prevFlush) checkOutput("valid cleared after flush", 128'(outValid), 128'(0));
         if (flush) checkOutput("no increment during flush", 128'(increment), 128'(0));
         if (prevHold) begin
            checkOutput("stalled item stays valid", 128'(outValid), 128'(1));
            checkOutput("stalled item unchanged", 128'({outMisaligned, outInstruction, outAddress}), 128'(prevItem));
         end
         if (prevInc) begin
            checkOutput("increment loads slot", 128'(outValid), 128'(1));
            checkOutput("increment item address", 128'(outAddress), 128'(prevPc));
         end
         if (prevReqWait) begin
            checkOutput("bus_req held until ack", 128'(busIf.req), 128'(1));
            checkOutput("bus_addr stable while held", 128'(busIf.addr), 128'(prevAddr));
         end
         if (outValid && outReady && !flush) begin
            handshakes++;
            if (expectQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected item: got address %0h, expected none (t=%0t)", outAddress, $time);
            end else begin
               expItem = expectQ.pop_front();
               checkOutput("fetched item", 128'({outMisaligned, outInstruction, outAddress}), 128'(expItem));
            end
         end
         prevFlush   = flush;
         prevHold    = outValid && !outReady && !flush;
         prevItem    = {outMisaligned, outInstruction, outAddress};
         prevInc     = increment;
         prevPc      = pcReg;
         prevReqWait = busIf.req && !busIf.ack;
         prevAddr    = busIf.addr;
      end
   end

   // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        doFlush;
      logic [31:0] tgt;
      int          sinceFlush;
      checks      = 0;
      errors      = 0;
      handshakes  = 0;
      reset       = 1'b0;
      flush       = 1'b0;
      flushTarget = 32'h0;
      outReady    = 1'b1;
      randomWaits = 1'b0;
      fixedWait   = 0;
      incSeen     = 1'b0;
      redirectModel(32'h0);

      #2 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkReset("reset");

      // Zero-wait streaming from pc 0: one word and one increment per cycle.
      @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) applyStimulus(1'b0, 32'h0, 1'b1);
         @(negedge clock);
         checkOutput("stream increment", 128'(increment), 128'(1));
         if (i > 0) begin
            checkOutput("stream valid", 128'(outValid), 128'(1));
            checkOutput("stream address", 128'(outAddress), 128'(32'(4 * (i - 1))));
         end
      end

      // Three wait cycles at 0x10, then a five-cycle downstream stall.
      fixedWait = 3;
      applyStimulus(1'b1, 32'h10, 1'b0);
      @(negedge clock);
      checkOutput("flush increment", 128'(increment), 128'(0));
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         @(negedge clock);
         checkOutput("wait bus_req", 128'(busIf.req), 128'(1));
         checkOutput("wait bus_addr", 128'(busIf.addr), 128'(32'h10));
         checkOutput("wait increment", 128'(increment), 128'(j == 3));
      end
      fixedWait = 0;
      for (int j = 0; j < 5; j++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         @(negedge clock);
         checkOutput("stall valid", 128'(outValid), 128'(1));
         checkOutput("stall address", 128'(outAddress), 128'(32'h10));
         checkOutput("stall bus_req", 128'(busIf.req), 128'(0));
         checkOutput("stall increment", 128'(increment), 128'(0));
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("resume increment", 128'(increment), 128'(1));

      // Flush during a waiting request at 0x20, redirect to 0x100.
      fixedWait = 3;
      applyStimulus(1'b1, 32'h20, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t4 request addr", 128'(busIf.addr), 128'(32'h20));
      fixedWait = 0;
      applyStimulus(1'b1, 32'h100, 1'b1);
      @(negedge clock);
      checkOutput("t4 flush bus_req held", 128'(busIf.req), 128'(1));
      checkOutput("t4 flush increment", 128'(increment), 128'(0));
      for (int j = 0; j < 2; j++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         @(negedge clock);
         checkOutput("t4 discard addr", 128'(busIf.addr), 128'(32'h20));
         checkOutput("t4 discard increment", 128'(increment), 128'(0));
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t4 refetch addr", 128'(busIf.addr), 128'(32'h100));
      checkOutput("t4 refetch increment", 128'(increment), 128'(1));
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t4 first item addr", 128'(outAddress), 128'(32'h100));

      // Flush while an item is valid, then flush coinciding with ack.
      fixedWait = 2;
      applyStimulus(1'b1, 32'h200, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t5 valid dropped", 128'(outValid), 128'(0));
      applyStimulus(1'b0, 32'h0, 1'b1);
      fixedWait = 0;
      applyStimulus(1'b1, 32'h300, 1'b1);
      @(negedge clock);
      checkOutput("t5 ack with flush", 128'(busIf.ack), 128'(1));
      checkOutput("t5 increment", 128'(increment), 128'(0));
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t5 valid after flush", 128'(outValid), 128'(0));
      checkOutput("t5 new addr", 128'(busIf.addr), 128'(32'h300));
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t5 first item addr", 128'(outAddress), 128'(32'h300));

      // Misaligned pc: fault item, then no bus activity until a redirect.
      applyStimulus(1'b1, 32'h102, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t6 no bus_req", 128'(busIf.req), 128'(0));
      checkOutput("t6 no increment", 128'(increment), 128'(0));
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t6 fault item", 128'({outValid, outMisaligned, outInstruction, outAddress}),
                  128'({1'b1, 1'b1, 32'h0, 32'h102}));
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         @(negedge clock);
         checkOutput("t6 halted bus_req", 128'(busIf.req), 128'(0));
      end

      // Reset in the middle of a long request.
      fixedWait = 5;
      applyStimulus(1'b1, 32'h400, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("t6 request after redirect", 128'(busIf.req), 128'(1));
      @(posedge clock);
      #1;
      reset = 1'b1;
      redirectModel(32'h0);
      #1;
      checkReset("mid-request reset");
      @(posedge clock);
      #1;
      checkReset("held reset");
      randomWaits = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;

      // Randomized traffic: random stalls, wait states and redirects.
      sinceFlush = 0;
      for (int c = 0; c < 1500; c++) begin
         doFlush = ($urandom_range(15, 0) == 0) || (sinceFlush >= 40);
         tgt = $urandom & 32'h0000_FFFC;
         if ($urandom_range(7, 0) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
         applyStimulus(doFlush, tgt, $urandom_range(3, 0) != 0);
         sinceFlush = doFlush ? 0 : sinceFlush + 1;
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clock);
      checkOutput("enough traffic", 128'(handshakes > 300), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
